// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer:
// stall vectors, exception codes and FSM states.
package pipe_ctrl_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [5:0] STALL_NONE = '0;
  localparam logic [5:0] STALL_ID   = {{3{NO_STOP}}, {3{STOP}}};
  localparam logic [5:0] STALL_EX   = {{2{NO_STOP}}, {4{STOP}}};
  localparam logic [5:0] STALL_MEM  = {NO_STOP, {5{STOP}}};

  localparam logic [31:0] EXC_NONE         = 32'h0000_0000;
  localparam logic [31:0] EXC_INTERRUPT    = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL      = 32'h0000_0008;
  localparam logic [31:0] EXC_INST_INVALID = 32'h0000_000a;
  localparam logic [31:0] EXC_OV           = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP         = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET         = 32'h0000_000e;

  typedef enum logic {
    S_RUN,
    S_WAIT_IF
  } state_e;

  function automatic logic [31:0] redirect_pc(
    input logic [31:0] exc,
    input logic [31:0] epc,
    input logic [31:0] vec
  );
    return (exc == EXC_ERET) ? epc : vec;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_monitor.sv
// Stall statistics: saturating total-stall counter,
// consecutive-stall run counter and sticky watchdog.
module stall_monitor
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter int unsigned RUN_W         = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_any_i,
  input  logic        flush_i,
  input  logic        clr_i,
  output logic [31:0] stall_cnt_o,
  output logic        timeout_o
);

  localparam logic [RUN_W-1:0] RUN_LAST =
    RUN_W'(STALL_TIMEOUT - 1);

  logic [31:0]      cnt_q, cnt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             to_q, to_d;

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    to_d  = to_q;
    if (clr_i)
      cnt_d = '0;
    else if (stall_any_i && cnt_q != '1)
      cnt_d = cnt_q + 32'd1;
    if (!stall_any_i || flush_i)
      run_d = '0;
    else if (run_q != '1)
      run_d = run_q + 1'b1;
    // clear has priority over a coincident watchdog hit
    if (clr_i)
      to_d = 1'b0;
    else if (stall_any_i && run_q == RUN_LAST)
      to_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      run_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
      to_q  <= to_d;
    end
  end

  assign stall_cnt_o = cnt_q;
  assign timeout_o   = to_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall requests, issues
// exception flushes, defers them behind in-flight fetches.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter int unsigned RUN_W         = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_if,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        clr_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cnt_o,
  output logic        timeout_o
);

  state_e      state_q, state_d;
  logic [31:0] pc_lat_q, pc_lat_d;
  logic [31:0] tgt;
  logic        exc;

  assign tgt = redirect_pc(excepttype_i, cp0_epc_i, EXC_VECTOR);
  assign exc = (excepttype_i != EXC_NONE);

  always_comb begin
    stall    = STALL_NONE;
    flush    = 1'b0;
    new_pc   = '0;
    state_d  = state_q;
    pc_lat_d = pc_lat_q;
    unique case (state_q)
      S_RUN: begin
        if (exc && !stallreq_from_if) begin
          flush  = 1'b1;
          new_pc = tgt;
        end else if (exc) begin
          // hold the faulting op in MEM until the fetch lands
          stall    = STALL_MEM;
          pc_lat_d = tgt;
          state_d  = S_WAIT_IF;
        end else if (stallreq_from_mem) begin
          stall = STALL_MEM;
        end else if (stallreq_from_ex) begin
          stall = STALL_EX;
        end else if (stallreq_from_id || stallreq_from_if) begin
          stall = STALL_ID;
        end
      end
      S_WAIT_IF: begin
        if (stallreq_from_if) begin
          stall = STALL_MEM;
        end else begin
          flush   = 1'b1;
          new_pc  = pc_lat_q;
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
    if (rst) begin
      stall  = STALL_NONE;
      flush  = 1'b0;
      new_pc = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RUN;
      pc_lat_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_lat_q <= pc_lat_d;
    end
  end

  stall_monitor #(
    .STALL_TIMEOUT(STALL_TIMEOUT),
    .RUN_W        (RUN_W)
  ) u_mon (
    .clk        (clk),
    .rst        (rst),
    .stall_any_i(stall != STALL_NONE),
    .flush_i    (flush),
    .clr_i      (clr_i),
    .stall_cnt_o(stall_cnt_o),
    .timeout_o  (timeout_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, flushes,
// deferred flush, watchdog and asynchronous reset.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        if_r, id_r, ex_r, mem_r;
  logic [31:0] exc_t, epc;
  logic        clr;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] cnt;
  logic        tmo;

  int total = 0;
  int bad   = 0;

  pipe_ctrl #(
    .EXC_VECTOR   (32'h0000_0020),
    .STALL_TIMEOUT(8),
    .RUN_W        (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_if (if_r),
    .stallreq_from_id (id_r),
    .stallreq_from_ex (ex_r),
    .stallreq_from_mem(mem_r),
    .excepttype_i     (exc_t),
    .cp0_epc_i        (epc),
    .clr_i            (clr),
    .stall            (stall),
    .flush            (flush),
    .new_pc           (new_pc),
    .stall_cnt_o      (cnt),
    .timeout_o        (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    if_r  = 0;
    id_r  = 0;
    ex_r  = 0;
    mem_r = 0;
    exc_t = 32'h0;
    clr   = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle();
    epc = 32'h0;
    mem_r = 1;
    #1;
    total++;
    if (stall !== 6'b000000) begin
      bad++;
      $display("FAIL reset_stall got=%b exp=000000", stall);
    end
    total++;
    if (flush !== 1'b0 || new_pc !== 32'h0) begin
      bad++;
      $display("FAIL reset_flush got=%b/%h exp=0/0", flush, new_pc);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (cnt !== 32'h0 || tmo !== 1'b0) begin
      bad++;
      $display("FAIL reset_mon got=%h/%b exp=0/0", cnt, tmo);
    end
    @(negedge clk);
    rst = 0;
    idle();
  endtask

  task automatic test_mem_ex();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_r = 1;
      ex_r  = 1;
      #1;
      total++;
      if (stall !== 6'b011111) begin
        bad++;
        $display("FAIL mem_ex_stall%0d got=%b exp=011111", i, stall);
      end
    end
    @(negedge clk);
    idle();
    #1;
    total++;
    if (stall !== 6'b000000) begin
      bad++;
      $display("FAIL mem_ex_release got=%b exp=000000", stall);
    end
    total++;
    if (cnt !== 32'd3) begin
      bad++;
      $display("FAIL mem_ex_cnt got=%0d exp=3", cnt);
    end
  endtask

  task automatic test_exc();
    @(negedge clk);
    exc_t = 32'h8;
    id_r  = 1;
    #1;
    total++;
    if (flush !== 1'b1 || new_pc !== 32'h20 || stall !== 6'b0) begin
      bad++;
      $display("FAIL exc_flush got=%b/%h/%b exp=1/20/000000",
               flush, new_pc, stall);
    end
    @(negedge clk);
    idle();
    #1;
    total++;
    if (cnt !== 32'd3) begin
      bad++;
      $display("FAIL exc_cnt got=%0d exp=3", cnt);
    end
  endtask

  task automatic test_eret();
    @(negedge clk);
    exc_t = 32'he;
    epc   = 32'h0000_1234;
    #1;
    total++;
    if (flush !== 1'b1 || new_pc !== 32'h0000_1234) begin
      bad++;
      $display("FAIL eret got=%b/%h exp=1/00001234", flush, new_pc);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_priority();
    @(negedge clk);
    id_r = 1;
    if_r = 1;
    #1;
    total++;
    if (stall !== 6'b000111) begin
      bad++;
      $display("FAIL prio_id got=%b exp=000111", stall);
    end
    @(negedge clk);
    idle();
    ex_r = 1;
    id_r = 1;
    #1;
    total++;
    if (stall !== 6'b001111) begin
      bad++;
      $display("FAIL prio_ex got=%b exp=001111", stall);
    end
    @(negedge clk);
    idle();
    if_r = 1;
    #1;
    total++;
    if (stall !== 6'b000111) begin
      bad++;
      $display("FAIL prio_if got=%b exp=000111", stall);
    end
    @(negedge clk);
    idle();
    #1;
    total++;
    if (cnt !== 32'd6) begin
      bad++;
      $display("FAIL prio_cnt got=%0d exp=6", cnt);
    end
  endtask

  task automatic test_wait_if();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if_r  = 1;
      exc_t = (i == 0) ? 32'hc : 32'he;
      epc   = (i < 2) ? 32'h0000_1234 : 32'h0000_5555;
      #1;
      total++;
      if (stall !== 6'b011111 || flush !== 1'b0) begin
        bad++;
        $display("FAIL wait_stall%0d got=%b/%b exp=011111/0",
                 i, stall, flush);
      end
    end
    @(negedge clk);
    if_r = 0;
    #1;
    total++;
    if (flush !== 1'b1 || new_pc !== 32'h20 || stall !== 6'b0) begin
      bad++;
      $display("FAIL wait_flush got=%b/%h/%b exp=1/20/000000",
               flush, new_pc, stall);
    end
    @(negedge clk);
    idle();
    #1;
    total++;
    if (flush !== 1'b0 || cnt !== 32'd10) begin
      bad++;
      $display("FAIL wait_after got=%b/%0d exp=0/10", flush, cnt);
    end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    clr = 1;
    @(negedge clk);
    clr = 0;
    #1;
    total++;
    if (cnt !== 32'd0) begin
      bad++;
      $display("FAIL to_clr0 got=%0d exp=0", cnt);
    end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      id_r = 1;
      @(posedge clk);
      #1;
      if (i == 7) begin
        total++;
        if (tmo !== 1'b0) begin
          bad++;
          $display("FAIL to_early got=%b exp=0", tmo);
        end
      end
      if (i == 8) begin
        total++;
        if (tmo !== 1'b1) begin
          bad++;
          $display("FAIL to_set got=%b exp=1", tmo);
        end
      end
    end
    @(negedge clk);
    idle();
    #1;
    total++;
    if (cnt !== 32'd8 || tmo !== 1'b1) begin
      bad++;
      $display("FAIL to_hold got=%0d/%b exp=8/1", cnt, tmo);
    end
    @(negedge clk);
    clr = 1;
    @(negedge clk);
    clr = 0;
    #1;
    total++;
    if (cnt !== 32'd0 || tmo !== 1'b0) begin
      bad++;
      $display("FAIL to_clr got=%0d/%b exp=0/0", cnt, tmo);
    end
  endtask

  task automatic test_reset_wait();
    @(negedge clk);
    exc_t = 32'hc;
    if_r  = 1;
    @(negedge clk);
    exc_t = 32'h0;
    #1;
    total++;
    if (stall !== 6'b011111) begin
      bad++;
      $display("FAIL rw_wait got=%b exp=011111", stall);
    end
    #2;
    rst = 1;
    #1;
    total++;
    if (stall !== 6'b0 || flush !== 1'b0) begin
      bad++;
      $display("FAIL rw_async got=%b/%b exp=000000/0", stall, flush);
    end
    idle();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (stall !== 6'b0 || flush !== 1'b0) begin
        bad++;
        $display("FAIL rw_after%0d got=%b/%b exp=000000/0",
                 i, stall, flush);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_mem_ex();
    test_exc();
    test_eret();
    test_priority();
    test_wait_if();
    test_timeout();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the six-stage OpenMIPS core (PC, IF, ID, EX, MEM, WB).
- Merges per-stage stall requests into the stall[5:0] vector consumed by every pipeline register, including the MEM/WB register.
- On a MEM-stage exception, raises flush and supplies the redirect PC. If an instruction-bus fetch is still in flight, it defers the flush until the fetch completes.
- Keeps stall statistics and a stall-timeout watchdog for debug.

Parameters:
- EXC_VECTOR, 32'h00000020, redirect target for all exceptions except eret.
- STALL_TIMEOUT, 1024, consecutive stall cycles that set timeout_o.
- RUN_W, 16, width of the consecutive-stall run counter; must satisfy STALL_TIMEOUT < 2^RUN_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- stallreq_from_if  in  1  instruction bus busy.
- stallreq_from_id  in  1  load-use / ID stall.
- stallreq_from_ex  in  1  multi-cycle EX op (div, madd).
- stallreq_from_mem  in  1  data bus busy.
- excepttype_i  in  32  MEM-stage exception code; 0 means none.
- cp0_epc_i  in  32  EPC from CP0, with forwarding already applied.
- clr_i  in  1  synchronous clear of stall_cnt_o and timeout_o.
- stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop.
- flush  out  1  flush all pipeline registers this cycle.
- new_pc  out  32  redirect PC, valid only while flush = 1.
- stall_cnt_o  out  32  total cycles with stall != 0, saturating.
- timeout_o  out  1  sticky watchdog flag.

Behaviour:
- While rst = 1: stall = 0, flush = 0, new_pc = 0; state goes to S_RUN; pc_lat, run counter, stall_cnt_o and timeout_o are all 0. rst asserted mid-operation aborts a pending flush.
- stall, flush and new_pc are combinational from state and inputs (zero latency). All other state is registered on the clk rising edge.
- Redirect target tgt:
  - excepttype_i == 32'h0000000e (eret): tgt = cp0_epc_i.
  - Any other non-zero code (0x1, 0x8, 0xa, 0xc, 0xd, ...): tgt = EXC_VECTOR.
- FSM has two states, S_RUN and S_WAIT_IF.
- S_RUN, excepttype_i != 0 and stallreq_from_if = 0:
  - flush = 1, stall = 0, new_pc = tgt.
  - Stay in S_RUN. Stall requests are ignored this cycle.
- S_RUN, excepttype_i != 0 and stallreq_from_if = 1:
  - flush = 0, stall = 6'b011111. This freezes MEM (the faulting instruction stays in MEM) and inserts a WB bubble.
  - pc_lat <= tgt; go to S_WAIT_IF.
- S_RUN, excepttype_i == 0: flush = 0; stall chosen by priority:
  - stallreq_from_mem -> 6'b011111
  - else stallreq_from_ex -> 6'b001111
  - else stallreq_from_id -> 6'b000111
  - else stallreq_from_if -> 6'b000111
  - else 6'b000000
- S_WAIT_IF, stallreq_from_if = 1: stall = 6'b011111, flush = 0. excepttype_i and all other requests are ignored.
- S_WAIT_IF, stallreq_from_if = 0: flush = 1, stall = 0, new_pc = pc_lat; go to S_RUN. pc_lat is used (not tgt) even if cp0_epc_i changed meanwhile.
- A flush cycle never counts as a stall cycle.
- stall_cnt_o:
  - +1 on each cycle with stall != 0; saturates at 32'hFFFFFFFF.
  - clr_i = 1 loads 0; clr wins over increment in the same cycle.
- Run counter:
  - Increments on each cycle with stall != 0, saturating at 2^RUN_W-1.
  - Cleared on any cycle with stall == 0, or on flush.
  - When it equals STALL_TIMEOUT-1 and stall != 0, timeout_o <= 1.
- timeout_o clears only on clr_i or rst. If clr_i and the set condition coincide, clr_i wins.

Decomposition:
- defines.v gains Stop/NoStop reuse, the exception codes (EXC_INTERRUPT, EXC_SYSCALL, EXC_INST_INVALID, EXC_TRAP, EXC_OV, EXC_ERET), and the state encodings S_RUN and S_WAIT_IF.
- One sub-module, stall_monitor, holds stall_cnt_o, the run counter and timeout_o. Its inputs are stall_any, flush and clr_i.

Test Plan:
- stallreq_from_mem = 1 and stallreq_from_ex = 1 for 3 cycles -> stall = 6'b011111 each cycle, then 0; stall_cnt_o = 3.
- excepttype_i = 32'h8, no IF busy -> flush = 1, new_pc = 32'h20, stall = 0 in the same cycle; stall_cnt_o unchanged.
- excepttype_i = 32'he, cp0_epc_i = 32'h0000_1234 -> flush = 1, new_pc = 32'h0000_1234.
- excepttype_i = 32'hc with stallreq_from_if = 1 for 4 cycles; cp0_epc_i changes mid-wait:
  - 4 cycles of stall = 6'b011111 with flush = 0.
  - Next cycle: flush = 1, new_pc = 32'h20.
- STALL_TIMEOUT = 8; stallreq_from_id held 8 cycles -> timeout_o = 1 after the 8th edge; clr_i pulse -> timeout_o = 0, stall_cnt_o = 0.
- rst pulsed while in S_WAIT_IF -> stall = 0 and flush = 0 immediately (asynchronous). After release, with no requests, stall = 0 and flush never fires.
